// File: rtl/axi4lite_slave_regbank_if.sv
// AXI4-Lite bus bundle between a master and the register-bank responder.
// Signal names follow the AXI4-Lite channel naming so existing hookups map one-to-one.
interface axi4lite_slave_regbank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    // Write data channel
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    // Write response channel
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    // Read address channel
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    // Read data channel
    logic                    RVALID;
    logic                    RREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, input AWREADY,
        output WVALID, WDATA, WSTRB, input WREADY,
        input  BVALID, BRESP, output BREADY,
        output ARVALID, ARADDR, ARPROT, input ARREADY,
        input  RVALID, RDATA, RRESP, output RREADY
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, output AWREADY,
        input  WVALID, WDATA, WSTRB, output WREADY,
        output BVALID, BRESP, input BREADY,
        input  ARVALID, ARADDR, ARPROT, output ARREADY,
        output RVALID, RDATA, RRESP, input RREADY
    );
endinterface

// File: rtl/axi4lite_slave_regbank.sv
// AXI4-Lite responder backed by NUM_REGS read/write registers.
// AW and W are accepted independently and held until both are present; the write
// commits on the edge where the second one arrives (or both together). Reads are
// served from the pre-write register state, so a same-edge read/write to one
// register returns the old value. Register contents are exported flat on regs_o.
module axi4lite_slave_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    axi4lite_slave_regbank_if.slave        bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    // Size of the decoded window in bytes; one extra bit so the compare never wraps.
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(NUM_REGS * STRB_W);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFS_W +: IDX_W];
    endfunction

    // Write-side state
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
    logic                  bvalid_q,  bvalid_d;
    resp_e                 bresp_q,   bresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Read-side state
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    resp_e                 rresp_q,   rresp_d;

    // Handshake and commit qualifiers
    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_in_range;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_in_range;
    logic [IDX_W-1:0]      rd_idx;

    // Protection attributes carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{bus.AWPROT, bus.ARPROT};

    assign bus.AWREADY = !aw_held_q && !bvalid_q;
    assign bus.WREADY  = !w_held_q && !bvalid_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = !rvalid_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

    assign aw_hs = bus.AWVALID && bus.AWREADY;
    assign w_hs  = bus.WVALID && bus.WREADY;
    assign ar_hs = bus.ARVALID && bus.ARREADY;

    // Select held or live write payload and decide whether this edge commits.
    always_comb begin
        wr_commit   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_addr     = aw_held_q ? awaddr_q : bus.AWADDR;
        wr_data     = w_held_q ? wdata_q : bus.WDATA;
        wr_strb     = w_held_q ? wstrb_q : bus.WSTRB;
        wr_in_range = addr_in_range(wr_addr);
        wr_idx      = addr_index(wr_addr);
        rd_in_range = addr_in_range(bus.ARADDR);
        rd_idx      = addr_index(bus.ARADDR);
    end

    // Write channel: capture AW/W, commit byte-strobed update, manage B response.
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        if (bvalid_q && bus.BREADY) begin
            bvalid_d = 1'b0;
        end

        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (wr_in_range) begin
                bresp_d = RESP_OKAY;
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = bus.AWADDR;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = bus.WDATA;
                wstrb_d  = bus.WSTRB;
            end
        end
    end

    // Read channel: sample pre-write register value on AR handshake, hold until R handshake.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && bus.RREADY) begin
            rvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (rd_in_range) begin
                rdata_d = regs_q[rd_idx];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    // Flatten the register array for downstream logic.
    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    // State registers; reset drops any in-flight transaction and partial captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regbank.sv
// Self-checking bench for axi4lite_slave_regbank: directed scenarios plus a
// randomized mix of reads and writes against an array-based register model.
module tb_axi4lite_slave_regbank;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NR  = 16;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NR*DW-1:0] regs_o;

    int n_checks = 0;
    int n_bad    = 0;

    logic [DW-1:0] model [NR];

    axi4lite_slave_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_slave_regbank #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] flat_model();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    // Register bank rule: byte-addressed, 4 bytes per register, 16 registers.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        if (addr < NR * 4) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr / 4][b*8 +: 8] = data[b*8 +: 8];
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        return (addr < NR * 4) ? model[addr / 4] : 32'h0;
    endfunction

    function automatic logic [1:0] model_rresp(input logic [31:0] addr);
        return (addr < NR * 4) ? 2'b00 : 2'b10;
    endfunction

    task automatic send_aw(input logic [31:0] addr, input int dly);
        int t = 0;
        repeat (dly) tick();
        bus.AWVALID = 1'b1;
        bus.AWADDR  = addr;
        bus.AWPROT  = 3'($urandom);
        while (!bus.AWREADY && t < TMO) begin tick(); t++; end
        chk("aw_accept", (t < TMO), 1);
        tick();
        bus.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        int t = 0;
        repeat (dly) tick();
        bus.WVALID = 1'b1;
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        while (!bus.WREADY && t < TMO) begin tick(); t++; end
        chk("w_accept", (t < TMO), 1);
        tick();
        bus.WVALID = 1'b0;
    endtask

    // Hold BREADY low for bd cycles, checking response stability and write backpressure.
    task automatic finish_b(input logic [1:0] exp_resp, input int bd);
        chk("bvalid", bus.BVALID, 1);
        chk("bresp", bus.BRESP, exp_resp);
        repeat (bd) begin
            tick();
            chk("b_hold", {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, {1'b1, exp_resp, 2'b00});
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        chk("b_done", {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int da, input int dw, input int bd);
        logic [1:0] er;
        fork
            send_aw(addr, da);
            send_w(data, strb, dw);
        join
        er = model_write(addr, data, strb);
        chk("regs_after_wr", regs_o, flat_model());
        finish_b(er, bd);
    endtask

    task automatic finish_r(input logic [31:0] ed, input logic [1:0] er, input int rd);
        chk("rvalid", bus.RVALID, 1);
        chk("rdata", bus.RDATA, ed);
        chk("rresp", bus.RRESP, er);
        repeat (rd) begin
            tick();
            chk("r_hold", {bus.RVALID, bus.RRESP, bus.RDATA, bus.ARREADY}, {1'b1, er, ed, 1'b0});
        end
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        chk("r_done", {bus.RVALID, bus.ARREADY}, 2'b01);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rd);
        int t = 0;
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        bus.ARPROT  = 3'($urandom);
        while (!bus.ARREADY && t < TMO) begin tick(); t++; end
        chk("ar_accept", (t < TMO), 1);
        tick();
        bus.ARVALID = 1'b0;
        finish_r(model_rdata(addr), model_rresp(addr), rd);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  er;

        bus.AWVALID = 0; bus.AWADDR = '0; bus.AWPROT = '0;
        bus.WVALID  = 0; bus.WDATA  = '0; bus.WSTRB  = '0;
        bus.BREADY  = 0;
        bus.ARVALID = 0; bus.ARADDR = '0; bus.ARPROT = '0;
        bus.RREADY  = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_valids", {bus.BVALID, bus.RVALID}, 2'b00);
        chk("rst_resps", {bus.BRESP, bus.RRESP}, 4'h0);
        chk("rst_rdata", bus.RDATA, 0);
        chk("rst_regs", regs_o, 0);
        chk("rst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        // 1: same-cycle AW+W then read back
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("t1_reg1", regs_o[1*DW +: DW], 32'hDEADBEEF);
        do_read(32'h04, 0);

        // 2: W ahead of AW, strobed partial write
        do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        send_w(32'h11223344, 4'h5, 0);
        repeat (3) begin
            chk("t2_no_commit", {bus.BVALID, regs_o}, {1'b0, flat_model()});
            tick();
        end
        send_aw(32'h08, 0);
        er = model_write(32'h08, 32'h11223344, 4'h5);
        chk("t2_reg2", regs_o[2*DW +: DW], 32'hFF22FF44);
        chk("t2_regs", regs_o, flat_model());
        finish_b(er, 0);
        tick();
        chk("t2_single_b", bus.BVALID, 0);

        // 3: B backpressure for 5 cycles
        do_write(32'h10, 32'hA5A5_0F0F, 4'hF, 1, 2, 5);

        // 4: out-of-range write and read
        do_write(32'h40, 32'h12345678, 4'hF, 0, 1, 2);
        do_read(32'h40, 1);
        chk("t4_regs", regs_o, flat_model());

        // 5: read and write commit to the same register on one edge
        do_write(32'h0C, 32'h1, 4'hF, 0, 0, 0);
        bus.AWVALID = 1; bus.AWADDR = 32'h0C;
        bus.WVALID  = 1; bus.WDATA  = 32'h2; bus.WSTRB = 4'hF;
        bus.ARVALID = 1; bus.ARADDR = 32'h0C;
        chk("t5_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        tick();
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        finish_r(32'h1, 2'b00, 0);
        er = model_write(32'h0C, 32'h2, 4'hF);
        finish_b(er, 0);
        do_read(32'h0C, 0);

        // 6: reset with a held AW and a pending R
        send_aw(32'h14, 0);
        bus.ARVALID = 1; bus.ARADDR = 32'h0;
        tick();
        bus.ARVALID = 0;
        chk("t6_rvalid_pre", bus.RVALID, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        chk("t6_valids", {bus.BVALID, bus.RVALID}, 2'b00);
        chk("t6_regs", regs_o, 0);
        send_w(32'hCAFEF00D, 4'hF, 0);
        repeat (3) begin
            chk("t6_no_b", bus.BVALID, 0);
            tick();
        end
        send_aw(32'h14, 0);
        er = model_write(32'h14, 32'hCAFEF00D, 4'hF);
        chk("t6_regs_commit", regs_o, flat_model());
        finish_b(er, 0);

        // Randomized mix of writes and reads
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)));
            end else begin
                do_read(a, int'($urandom_range(0, 3)));
            end
        end
        chk("final_regs", regs_o, flat_model());

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
